// File: rtl/lut_neuron_loader.sv
// Writable truth-table neuron: a streamed config image fills a 2^IN_BITS x OUT_BITS
// table, and a valid/ready lookup port returns table[in_data] through a registered output.
module lut_neuron_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int TBITS  = (2 ** IN_BITS) * OUT_BITS;
  localparam int NWORDS = TBITS / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int IDX_W  = (TBITS > 1) ? $clog2(TBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 cfg_err_reg, cfg_err_next;
  logic                 out_valid_reg;
  logic [OUT_BITS-1:0]  out_data_reg;

  logic                 cfg_fire;
  logic                 in_fire;
  logic                 wr_en;
  logic [CNT_W-1:0]     wr_word;
  logic [IDX_W-1:0]     rd_base;

  logic [WORD_W-1:0]    table_mem [NWORDS];
  logic [TBITS-1:0]     table_flat;

  // Config is held off while a lookup result is pending so a table write never
  // races a result that is still waiting to be consumed.
  assign cfg_ready = (state_reg != S_RUN) || !out_valid_reg;
  assign in_ready  = (state_reg == S_RUN) && (!out_valid_reg || out_ready);
  assign loaded    = (state_reg == S_RUN);
  assign cfg_err   = cfg_err_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_EMPTY;
      cnt_reg     <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cfg_err_next = 1'b0;
    wr_en        = 1'b0;
    wr_word      = '0;

    case (state_reg)
      S_EMPTY, S_RUN: begin
        if (cfg_fire) begin
          wr_en   = 1'b1;
          wr_word = '0;
          if (NWORDS == 1) begin
            cnt_next = '0;
            if (cfg_last) begin
              state_next = S_RUN;
            end else begin
              cfg_err_next = 1'b1;
              state_next   = S_EMPTY;
            end
          end else if (cfg_last) begin
            cfg_err_next = 1'b1;
            state_next   = S_EMPTY;
            cnt_next     = '0;
          end else begin
            state_next = S_LOAD;
            cnt_next   = CNT_W'(1);
          end
        end
      end

      S_LOAD: begin
        if (cfg_fire) begin
          wr_en    = 1'b1;
          wr_word  = cnt_reg;
          cnt_next = '0;
          if (cnt_reg == LAST_CNT) begin
            if (cfg_last) begin
              state_next = S_RUN;
            end else begin
              cfg_err_next = 1'b1;
              state_next   = S_EMPTY;
            end
          end else if (cfg_last) begin
            cfg_err_next = 1'b1;
            state_next   = S_EMPTY;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      default: begin
        state_next = S_EMPTY;
        cnt_next   = '0;
      end
    endcase
  end

  // Table storage carries no reset: its contents are only observable once a
  // complete image has been written, which always overwrites every word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_mem[wr_word] <= cfg_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_flat
      assign table_flat[gi*WORD_W +: WORD_W] = table_mem[gi];
    end
  endgenerate

  // Entries may straddle word boundaries when OUT_BITS does not divide WORD_W,
  // so the lookup indexes the flattened bit image rather than a single word.
  assign rd_base = IDX_W'(in_data) * IDX_W'(OUT_BITS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (in_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= table_flat[rd_base +: OUT_BITS];
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Randomized scoreboard bench for lut_neuron_loader: a table-level reference model
// predicts each lookup, and a negedge monitor retires results in order.
module tb_lut_neuron_loader;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 1;
  localparam int WORD_W   = 32;
  localparam int NENT     = 2 ** IN_BITS;
  localparam int NWORDS   = NENT * OUT_BITS / WORD_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [WORD_W-1:0]   cfg_data = '0;
  logic                cfg_last = 1'b0;
  logic                cfg_err;
  logic                loaded;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [OUT_BITS-1:0] out_data;

  lut_neuron_loader #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .WORD_W  (WORD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .cfg_last (cfg_last),
    .cfg_err  (cfg_err),
    .loaded   (loaded),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [OUT_BITS-1:0] model   [NENT];
  logic [OUT_BITS-1:0] img_ent [NENT];
  logic [WORD_W-1:0]   img_w   [NWORDS];
  logic [OUT_BITS-1:0] exp_q [$];

  bit b2b_mode = 1'b0;
  int pops = 0;
  int first_pop = 0;
  int last_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference image is defined entry by entry; words are derived from it.
  task automatic pack_image();
    for (int w = 0; w < NWORDS; w++)
      for (int b = 0; b < WORD_W; b++)
        img_w[w][b] = img_ent[(w * WORD_W + b) / OUT_BITS][(w * WORD_W + b) % OUT_BITS];
  endtask

  task automatic random_image();
    for (int k = 0; k < NENT; k++) img_ent[k] = OUT_BITS'($urandom);
    pack_image();
  endtask

  // Monitor: compares every retired result against the scoreboard head.
  always @(negedge clk) begin
    logic [OUT_BITS-1:0] e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
        $display("lookup result %0h expected %0h at cycle %0d", out_data, e, cyc);
        if (b2b_mode) begin
          if (pops > 0) chk("b2b_gap", 32'(cyc - last_pop), 32'd1);
          else first_pop = cyc;
        end
        last_pop = cyc;
        pops++;
      end else begin
        chk("stall_out_data", 32'(out_data), 32'(exp_q[0]));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
    end
  end

  // All drivers start and end at 1 time unit after a rising edge.
  task automatic cfg_beat(input logic [WORD_W-1:0] d, input logic last);
    bit done;
    done = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      done = cfg_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("cfg_ready_timeout", 32'd0, 32'd1);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic load_image(input int nbeats, input int last_at, input bit exp_err);
    bit commit;
    commit = (nbeats == NWORDS) && (last_at == NWORDS - 1);
    for (int i = 0; i < nbeats; i++) begin
      if (i == nbeats - 1 && i > 0) begin
        @(negedge clk);
        chk("loaded_before_final_beat", 32'(loaded), 32'd0);
        @(posedge clk);
        #1;
      end
      cfg_beat(img_w[i], i == last_at);
    end
    $display("config load of %0d beats, last at %0d, at cycle %0d", nbeats, last_at, cyc);
    if (commit)
      for (int k = 0; k < NENT; k++) model[k] = img_ent[k];
    @(negedge clk);
    chk("loaded_after_load", 32'(loaded), 32'(commit));
    chk("cfg_err_pulse", 32'(cfg_err), 32'(exp_err));
    if (!commit) chk("in_ready_not_loaded", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [IN_BITS-1:0] code, input bit chk_lat);
    bit fired;
    fired = 1'b0;
    in_valid = 1'b1;
    in_data  = code;
    for (int n = 0; n < 60 && !fired; n++) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      if (fired) exp_q.push_back(model[code]);
      #1;
    end
    in_valid = 1'b0;
    if (!fired) chk("in_ready_timeout", 32'd0, 32'd1);
    else if (chk_lat) begin
      @(negedge clk);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single hot entry at 48 and its neighbours
    for (int k = 0; k < NENT; k++) img_ent[k] = '0;
    img_ent[48] = 1'b1;
    pack_image();
    load_image(NWORDS, NWORDS - 1, 1'b0);
    lookup(8'd48, 1'b1);
    lookup(8'd47, 1'b1);
    lookup(8'd49, 1'b1);
    drain();

    // Full sweep at full throughput against entry k = k[0]^k[7]
    for (int k = 0; k < NENT; k++) begin
      logic [7:0] kk;
      kk = 8'(k);
      img_ent[k] = OUT_BITS'(kk[0] ^ kk[7]);
    end
    pack_image();
    load_image(NWORDS, NWORDS - 1, 1'b0);
    b2b_mode = 1'b1;
    pops = 0;
    for (int k = 0; k < NENT; k++) lookup(8'(k), 1'b0);
    drain();
    b2b_mode = 1'b0;
    chk("b2b_count", 32'(pops), 32'(NENT));
    chk("b2b_span", 32'(last_pop - first_pop), 32'(NENT - 1));

    // Backpressure: out_ready low for 5 cycles with a result pending
    random_image();
    load_image(NWORDS, NWORDS - 1, 1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) lookup(8'($urandom_range(0, NENT - 1)), 1'b0);
      end
      begin
        out_ready = 1'b0;
        @(posedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Early last on word 3, missing last on word 7, then a clean reload
    random_image();
    load_image(4, 3, 1'b1);
    load_image(NWORDS, -1, 1'b1);
    load_image(NWORDS, NWORDS - 1, 1'b0);
    for (int i = 0; i < 20; i++) lookup(8'($urandom_range(0, NENT - 1)), 1'b0);
    drain();

    // Reload requested while a result is pending
    out_ready = 1'b0;
    lookup(8'($urandom_range(0, NENT - 1)), 1'b0);
    random_image();
    cfg_valid = 1'b1;
    cfg_data  = img_w[0];
    repeat (3) begin
      @(negedge clk);
      chk("cfg_ready_gated", 32'(cfg_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    load_image(NWORDS, NWORDS - 1, 1'b0);
    for (int k = 0; k < NENT; k++) lookup(8'(k), 1'b0);
    drain();

    // Reset after 4 words of a load, then a fresh full load
    random_image();
    for (int i = 0; i < 4; i++) cfg_beat(img_w[i], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midload_rst_loaded", 32'(loaded), 32'd0);
    chk("midload_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midload_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    random_image();
    load_image(NWORDS, NWORDS - 1, 1'b0);
    for (int i = 0; i < 30; i++) lookup(8'($urandom_range(0, NENT - 1)), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_neuron_loader.md
Name: lut_neuron_loader

Overview:
- Runtime-programmable truth-table neuron: IN_BITS-bit input code maps to an OUT_BITS-bit output through a table written over a streaming config port.
- Serves as the writable counterpart of the fixed-ROM layer neurons, so a trained table can be swapped in on-board without resynthesis.
- The config side writes the table. The lookup side reads it behind a valid/ready stream with a registered output.

Parameters:
- IN_BITS, 8, neuron input width. The table has 2^IN_BITS entries.
- OUT_BITS, 1, bits per table entry.
- WORD_W, 32, config word width. (2^IN_BITS*OUT_BITS) must be a multiple of WORD_W.
- Derived constant NWORDS = 2^IN_BITS*OUT_BITS/WORD_W, which is 8 at the defaults.

Ports:
- clk        in   1         sole clock; all logic on the rising edge
- rst_n      in   1         synchronous reset, active-low
- cfg_valid  in   1         config word valid
- cfg_ready  out  1         config word accepted when cfg_valid && cfg_ready
- cfg_data   in   WORD_W    table bits, LSB-first
- cfg_last   in   1         marks the final word of a table image
- cfg_err    out  1         one-cycle pulse on a malformed image
- loaded     out  1         a complete table is resident
- in_valid   in   1         lookup request valid
- in_ready   out  1         lookup accepted when in_valid && in_ready
- in_data    in   IN_BITS   input code, unsigned, in_data[IN_BITS-1] is the MSB
- out_valid  out  1         lookup result valid
- out_ready  in   1         downstream accepts the result
- out_data   out  OUT_BITS  table entry for the accepted code

Behaviour:

Reset (rst_n=0 at a clk edge):
- State becomes EMPTY and the word counter becomes 0.
- Outputs: loaded=0, out_valid=0, out_data=0, cfg_err=0.
- Table contents are don't-care and are never read while loaded=0.
- A reset mid-load or mid-lookup drops everything in flight. No partial table becomes usable.

Table layout:
- Entry k occupies table bits [k*OUT_BITS +: OUT_BITS].
- Word w written during a load fills table bits [w*WORD_W +: WORD_W].
- Bit 0 of word 0 is entry 0, LSB.

States:
- EMPTY: cfg_ready=1, in_ready=0, loaded=0.
- LOAD: cfg_ready=1, in_ready=0, loaded=0.
- RUN: loaded=1.
  - cfg_ready = !out_valid. Config is accepted only once the output register has drained.
  - in_ready = !out_valid || out_ready.

Transitions:
- EMPTY or RUN, on a config beat: write word 0, set cnt=1, go to LOAD.
  - A beat arriving in RUN restarts loading and clears loaded in the next cycle.
- LOAD, on a config beat: write word cnt, then increment cnt.
  - If cnt==NWORDS-1 and cfg_last=1: go to RUN, set loaded=1 from the next cycle, reset cnt to 0.
  - If cfg_last=1 and cnt<NWORDS-1 (early last): pulse cfg_err, go to EMPTY.
  - If cnt==NWORDS-1 and cfg_last=0 (missing last): pulse cfg_err, go to EMPTY.
- In the EMPTY/RUN beat above, cfg_last=1 on word 0 is an error (pulse cfg_err, go to EMPTY) unless NWORDS==1.
- cfg_err is high for exactly one cycle per error event.

Lookup (RUN only):
- On accept, on the next edge: out_data = table[in_data], out_valid=1. Latency is 1 cycle.
- out_valid && !out_ready: out_data and out_valid hold stable and in_ready=0.
- out_valid && out_ready && in_valid: the old result retires and the new result loads in the same edge. This gives full throughput, 1 result/cycle.
- out_valid && out_ready && !in_valid: out_valid clears.
- Table writes never coincide with a pending result, because cfg_ready is gated by out_valid.

Test Plan:
- Load 8 words 0x00000000 except word 1 = 0x00010000 (entry 48 = 1), cfg_last on word 7 -> loaded rises 1 cycle after the last beat; lookups of 48 -> out_data=1, 47 and 49 -> 0, each 1 cycle after accept.
- Back-to-back lookups 0..255 with out_ready=1 against an image with entry k = k[0]^k[7] -> 256 results in 256 consecutive cycles, all matching the model.
- out_ready held low for 5 cycles with out_valid=1 -> out_data stable, in_ready=0, no request lost; then release -> remaining results emitted in order.
- cfg_last on word 3 -> cfg_err pulses 1 cycle, loaded=0, in_ready=0; then a full valid reload -> loaded=1 and correct lookups.
- Reload while RUN with a result pending -> cfg_ready=0 until out_valid clears; after the new image loads, lookups return new values with no mixing of old and new words.
- rst_n low for 1 cycle in mid-load after 4 words -> loaded=0, out_valid=0; a subsequent 8-word load succeeds from word 0.
